// File: rtl/proc_ctrl_fsm.sv
// Instruction-sequencing controller for the 16-bit processor datapath.
// Define PROC_CTRL_ILLEGAL_TRAP_EN to send illegal opcodes to a sticky TRAP state.
module proc_ctrl_fsm #(
    parameter int OPC_W     = 4,
    parameter int RF_ADDR_W = 4,
    parameter int INSTR_W   = 16,
    parameter int DADDR_W   = 8,
    parameter int MEM_LAT   = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [INSTR_W-1:0]   Instr,
    input  logic                 RFAZero,
    output logic                 PCClr,
    output logic                 PCUp,
    output logic                 PCLd,
    output logic [DADDR_W-1:0]   PCLdVal,
    output logic                 IRLd,
    output logic [DADDR_W-1:0]   DAddr,
    output logic                 DWrite,
    output logic [RF_ADDR_W-1:0] RFAReadAddr,
    output logic [RF_ADDR_W-1:0] RFBReadAddr,
    output logic [1:0]           RFSelect,
    output logic [DADDR_W-1:0]   RFImm,
    output logic [RF_ADDR_W-1:0] RFWriteAddr,
    output logic                 RFWriteEnable,
    output logic [2:0]           ALUSelect,
    output logic                 Halted,
    output logic                 Trap,
    output logic [3:0]           StateOut,
    output logic [3:0]           NextStateOut
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    localparam logic [OPC_W-1:0] OP_NOOP  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_LDI   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JZ    = OPC_W'(7);

    typedef enum logic [3:0] {
        S_NOOP   = 4'h0,
        S_STORE  = 4'h1,
        S_LOAD_A = 4'h2,
        S_ADD    = 4'h3,
        S_SUB    = 4'h4,
        S_HALT   = 4'h5,
        S_LOAD_B = 4'h6,
        S_LDI    = 4'h7,
        S_INIT   = 4'h8,
        S_JZ     = 4'h9,
        S_LOAD_W = 4'hA,
        S_TRAP   = 4'hB,
        S_DECODE = 4'hC,
        S_FETCH  = 4'hF
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic [OPC_W-1:0]     opc;
    logic [RF_ADDR_W-1:0] f1, f2, f3;

    assign opc = Instr[INSTR_W-1 -: OPC_W];
    assign f1  = Instr[INSTR_W-OPC_W-1 -: RF_ADDR_W];
    assign f2  = Instr[INSTR_W-OPC_W-RF_ADDR_W-1 -: RF_ADDR_W];
    assign f3  = Instr[RF_ADDR_W-1:0];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OP_NOOP:  state_nxt = S_NOOP;
                    OP_STORE: state_nxt = S_STORE;
                    OP_LOAD:  state_nxt = S_LOAD_A;
                    OP_ADD:   state_nxt = S_ADD;
                    OP_SUB:   state_nxt = S_SUB;
                    OP_HALT:  state_nxt = S_HALT;
                    OP_LDI:   state_nxt = S_LDI;
                    OP_JZ:    state_nxt = S_JZ;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
                    default:  state_nxt = S_TRAP;
`else
                    default:  state_nxt = S_NOOP;
`endif
                endcase
            end
            S_NOOP, S_STORE, S_ADD, S_SUB, S_LDI, S_JZ, S_LOAD_B:
                state_nxt = S_FETCH;
            S_LOAD_A: begin
                cnt_nxt   = LAT_M1;
                state_nxt = (MEM_LAT > 1) ? S_LOAD_W : S_LOAD_B;
            end
            // Counter holds the remaining wait cycles including this one.
            S_LOAD_W: begin
                cnt_nxt   = cnt - 1'b1;
                state_nxt = (cnt <= CNT_W'(1)) ? S_LOAD_B : S_LOAD_W;
            end
            S_HALT:   state_nxt = S_HALT;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:   state_nxt = S_TRAP;
`endif
            default:  state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        PCClr         = 1'b0;
        PCUp          = 1'b0;
        PCLd          = 1'b0;
        PCLdVal       = '0;
        IRLd          = 1'b0;
        DAddr         = '0;
        DWrite        = 1'b0;
        RFAReadAddr   = '0;
        RFBReadAddr   = '0;
        RFSelect      = 2'b00;
        RFImm         = '0;
        RFWriteAddr   = '0;
        RFWriteEnable = 1'b0;
        ALUSelect     = 3'b000;
        Halted        = 1'b0;
        Trap          = 1'b0;
        case (state)
            S_INIT:  PCClr = 1'b1;
            S_FETCH: begin
                IRLd = 1'b1;
                PCUp = 1'b1;
            end
            S_STORE: begin
                DAddr       = {f2, f3};
                RFAReadAddr = f1;
                DWrite      = 1'b1;
            end
            S_LOAD_A, S_LOAD_W, S_LOAD_B: begin
                DAddr         = {f1, f2};
                RFSelect      = 2'b01;
                RFWriteAddr   = f3;
                RFWriteEnable = (state == S_LOAD_B);
            end
            S_ADD, S_SUB: begin
                RFAReadAddr   = f1;
                RFBReadAddr   = f2;
                RFWriteAddr   = f3;
                ALUSelect     = (state == S_ADD) ? 3'b001 : 3'b010;
                RFWriteEnable = 1'b1;
            end
            S_LDI: begin
                RFImm         = {f1, f2};
                RFSelect      = 2'b10;
                RFWriteAddr   = f3;
                RFWriteEnable = 1'b1;
            end
            // JZ is never reached from FETCH, so PCLd and PCUp cannot overlap.
            S_JZ: begin
                RFAReadAddr = f1;
                PCLdVal     = {f2, f3};
                PCLd        = RFAZero;
            end
            S_HALT:  Halted = 1'b1;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                Trap   = 1'b1;
                Halted = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign StateOut     = state;
    assign NextStateOut = state_nxt;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: per-instruction cycle sequences from a list-based model.
module tb_proc_ctrl_fsm;

    localparam int MEM_LAT = 3;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] Instr;
    logic        RFAZero;
    logic        PCClr, PCUp, PCLd, IRLd, DWrite, RFWriteEnable, Halted, Trap;
    logic [7:0]  PCLdVal, DAddr, RFImm;
    logic [3:0]  RFAReadAddr, RFBReadAddr, RFWriteAddr, StateOut, NextStateOut;
    logic [1:0]  RFSelect;
    logic [2:0]  ALUSelect;

    proc_ctrl_fsm #(.OPC_W(4), .RF_ADDR_W(4), .INSTR_W(16), .DADDR_W(8), .MEM_LAT(MEM_LAT)) dut (
        .Clk(Clk), .Rst(Rst), .Instr(Instr), .RFAZero(RFAZero),
        .PCClr(PCClr), .PCUp(PCUp), .PCLd(PCLd), .PCLdVal(PCLdVal), .IRLd(IRLd),
        .DAddr(DAddr), .DWrite(DWrite), .RFAReadAddr(RFAReadAddr), .RFBReadAddr(RFBReadAddr),
        .RFSelect(RFSelect), .RFImm(RFImm), .RFWriteAddr(RFWriteAddr),
        .RFWriteEnable(RFWriteEnable), .ALUSelect(ALUSelect), .Halted(Halted), .Trap(Trap),
        .StateOut(StateOut), .NextStateOut(NextStateOut)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcclr, pcup, pcld;
        logic [7:0] pcldval;
        logic       irld;
        logic [7:0] daddr;
        logic       dwrite;
        logic [3:0] ra, rb;
        logic [1:0] rsel;
        logic [7:0] imm;
        logic [3:0] wa;
        logic       we;
        logic [2:0] alu;
        logic       halted, trap;
    } rec_t;

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];
    logic [3:0] after_st;

    function automatic rec_t blank(input logic [3:0] st);
        rec_t r;
        r = '0;
        r.st = st;
        return r;
    endfunction

    function automatic rec_t snap();
        rec_t r;
        r = {StateOut, PCClr, PCUp, PCLd, PCLdVal, IRLd, DAddr, DWrite, RFAReadAddr,
             RFBReadAddr, RFSelect, RFImm, RFWriteAddr, RFWriteEnable, ALUSelect, Halted, Trap};
        return r;
    endfunction

    // Reference: the list of cycles an instruction occupies, starting at its FETCH.
    task automatic build(input logic [15:0] ins, input logic z);
        rec_t r;
        logic [3:0] op, f1, f2, f3;
        op = ins[15:12]; f1 = ins[11:8]; f2 = ins[7:4]; f3 = ins[3:0];
        exp_q.delete();
        after_st = 4'hF;
        r = blank(4'hF); r.irld = 1'b1; r.pcup = 1'b1; exp_q.push_back(r);
        exp_q.push_back(blank(4'hC));
        case (op)
            4'd1: begin
                r = blank(4'h1); r.daddr = {f2, f3}; r.ra = f1; r.dwrite = 1'b1; exp_q.push_back(r);
            end
            4'd2: begin
                r = blank(4'h2); r.daddr = {f1, f2}; r.rsel = 2'b01; r.wa = f3; exp_q.push_back(r);
                r.st = 4'hA;
                for (int k = 1; k < MEM_LAT; k++) exp_q.push_back(r);
                r.st = 4'h6; r.we = 1'b1; exp_q.push_back(r);
            end
            4'd3, 4'd4: begin
                r = blank(op); r.ra = f1; r.rb = f2; r.wa = f3; r.we = 1'b1;
                r.alu = (op == 4'd3) ? 3'b001 : 3'b010; exp_q.push_back(r);
            end
            4'd5: begin
                r = blank(4'h5); r.halted = 1'b1; exp_q.push_back(r); after_st = 4'h5;
            end
            4'd6: begin
                r = blank(4'h7); r.imm = {f1, f2}; r.rsel = 2'b10; r.wa = f3; r.we = 1'b1;
                exp_q.push_back(r);
            end
            4'd7: begin
                r = blank(4'h9); r.ra = f1; r.pcldval = {f2, f3}; r.pcld = z; exp_q.push_back(r);
            end
            4'd0: exp_q.push_back(blank(4'h0));
            default: begin
                if (TRAP_EN) begin
                    r = blank(4'hB); r.trap = 1'b1; r.halted = 1'b1; exp_q.push_back(r);
                    after_st = 4'hB;
                end else begin
                    exp_q.push_back(blank(4'h0));
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input rec_t e, input logic [3:0] nxt);
        rec_t a;
        a = snap();
        checks++;
        assert (a === e) else begin
            errors++;
            $error("FAIL %s outputs: observed %h expected %h", tag, a, e);
        end
        checks++;
        assert (NextStateOut === nxt) else begin
            errors++;
            $error("FAIL %s next_state: observed %h expected %h", tag, NextStateOut, nxt);
        end
    endtask

    // Called at the falling edge while in FETCH; returns at the falling edge after the instruction.
    task automatic run_instr(input logic [15:0] ins, input logic z);
        string tag;
        Instr = ins;
        RFAZero = z;
        build(ins, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            tag = $sformatf("instr_%h_c%0d", ins, i);
            check(tag, exp_q[i], (i + 1 < exp_q.size()) ? exp_q[i+1].st : after_st);
            @(negedge Clk);
        end
    endtask

    rec_t r_init;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd;
        logic [3:0]  op;
        r_init = blank(4'h8);
        r_init.pcclr = 1'b1;

        Rst = 1'b0; Instr = 16'h0000; RFAZero = 1'b0;
        @(negedge Clk);
        check("reset", r_init, 4'hF);
        Rst = 1'b1;
        @(negedge Clk);

        run_instr(16'h3123, 1'b0);
        run_instr(16'h4123, 1'b0);
        run_instr(16'h2AB5, 1'b0);
        run_instr(16'h7142, 1'b1);
        run_instr(16'h7142, 1'b0);
        run_instr(16'h65A7, 1'b1);
        run_instr(16'h1C3D, 1'b0);
        run_instr(16'h0FFF, 1'b1);

        for (int n = 0; n < 40; n++) begin
            do begin
                op = 4'($urandom_range(0, 15));
            end while (op == 4'd5 || (TRAP_EN && op > 4'd7));
            rnd = $urandom;
            run_instr({op, rnd[11:0]}, rnd[12]);
        end

        // Asynchronous reset in the middle of the LOAD wait.
        Instr = 16'h2AB5;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        assert (StateOut === 4'hA) else begin
            errors++;
            $error("FAIL load_wait_reached: observed %h expected %h", StateOut, 4'hA);
        end
        #2 Rst = 1'b0;
        #1 check("async_reset_mid_load", r_init, 4'hF);
        @(negedge Clk);
        check("reset_hold_1", r_init, 4'hF);
        @(negedge Clk);
        check("reset_hold_2", r_init, 4'hF);
        Rst = 1'b1;
        @(negedge Clk);
        run_instr(16'h2AB5, 1'b0);

        run_instr(16'h9000, 1'b0);
        if (TRAP_EN) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("trap_hold_%0d", i), exp_q[exp_q.size()-1], 4'hB);
                @(negedge Clk);
            end
            Rst = 1'b0;
            #1 check("reset_from_trap", r_init, 4'hF);
            @(negedge Clk);
            Rst = 1'b1;
            @(negedge Clk);
        end

        run_instr(16'h5000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("halt_hold_%0d", i), exp_q[exp_q.size()-1], 4'h5);
            @(negedge Clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
